// File: rtl/sqrt_core_pkg.sv
// Shared constants, flag indices and FSM encoding for the iterative square-root core.
package sqrt_core_pkg;

    localparam int EXP_SIZE   = 11;
    localparam int IN_M_SIZE  = 106;
    localparam int OUT_M_SIZE = 53;
    localparam int BIAS       = 1023;
    localparam int REM_SIZE   = OUT_M_SIZE + 2;
    localparam int CNT_SIZE   = $clog2(OUT_M_SIZE);

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Biased exponent of the root: (e + BIAS) / 2, one extra bit so the sum cannot wrap.
    function automatic logic [EXP_SIZE-1:0] half_exp(input logic [EXP_SIZE-1:0] e);
        logic [EXP_SIZE:0] w_sum;
        w_sum = {1'b0, e} + (EXP_SIZE + 1)'(BIAS);
        return w_sum[EXP_SIZE:1];
    endfunction

endpackage

// File: rtl/sqrt_core_if.sv
// Operand/result bundle between the sqrt input wrapper (master) and the core (slave).
interface sqrt_core_if;
    import sqrt_core_pkg::*;

    logic                  start_sqrt;
    logic [IN_M_SIZE-1:0]  in_mantisa;
    logic [EXP_SIZE-1:0]   in_exp;
    logic [2:0]            in_flags;
    logic                  in_type;
    logic [OUT_M_SIZE-1:0] out_mantisa;
    logic [EXP_SIZE-1:0]   out_exp;
    logic [2:0]            out_flags;
    logic                  out_type;
    logic                  sticky;
    logic                  ready;

    modport master (
        output start_sqrt, in_mantisa, in_exp, in_flags, in_type,
        input  out_mantisa, out_exp, out_flags, out_type, sticky, ready
    );

    modport slave (
        input  start_sqrt, in_mantisa, in_exp, in_flags, in_type,
        output out_mantisa, out_exp, out_flags, out_type, sticky, ready
    );

endinterface

// File: rtl/sqrt_core_cu.sv
// Control unit: IDLE/CALC/DONE sequencer issuing load, run and the one-cycle ready pulse.
module sqrt_core_cu
    import sqrt_core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_special,
    input  logic i_tc,
    output logic o_ld,
    output logic o_run,
    output logic o_ready
);

    state_t r_state;
    logic   r_run;
    logic   r_ready;

    // Load must act on the very edge that samples start, so it is decoded rather than registered.
    assign o_ld    = (r_state == IDLE) && i_start;
    assign o_run   = r_run;
    assign o_ready = r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= i_special ? DONE : CALC;
                        r_run   <= !i_special;
                    end
                end
                CALC: begin
                    if (i_tc) begin
                        r_state <= DONE;
                        r_run   <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sqrt_core_dp.sv
// Datapath: radicand shifter, restoring remainder/root step, exponent halving, bit counter.
module sqrt_core_dp
    import sqrt_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ld,
    input  logic                  i_run,
    input  logic [IN_M_SIZE-1:0]  i_mantisa,
    input  logic [EXP_SIZE-1:0]   i_exp,
    input  logic [2:0]            i_flags,
    input  logic                  i_type,
    output logic                  o_tc,
    output logic                  o_special,
    output logic [OUT_M_SIZE-1:0] o_mantisa,
    output logic [EXP_SIZE-1:0]   o_exp,
    output logic [2:0]            o_flags,
    output logic                  o_type,
    output logic                  o_sticky
);

    logic [IN_M_SIZE-1:0]  r_rad;
    logic [REM_SIZE-1:0]   r_rem;
    logic [OUT_M_SIZE-1:0] r_root;
    logic [CNT_SIZE-1:0]   r_cnt;
    logic [EXP_SIZE-1:0]   r_exp;
    logic [2:0]            r_flags;
    logic                  r_type;

    logic [REM_SIZE-1:0]   w_trial;
    logic [REM_SIZE-1:0]   w_t;
    logic                  w_ge;
    logic [REM_SIZE-1:0]   w_rem_next;
    logic [OUT_M_SIZE-1:0] w_root_next;

    // The remainder never exceeds 2*root, so its top two bits are zero before the shift.
    assign w_trial     = {r_rem[REM_SIZE-3:0], r_rad[IN_M_SIZE-1 -: 2]};
    assign w_t         = {r_root, 2'b01};
    assign w_ge        = (w_trial >= w_t);
    assign w_rem_next  = w_ge ? (w_trial - w_t) : w_trial;
    assign w_root_next = {r_root[OUT_M_SIZE-2:0], w_ge};

    assign o_tc      = (r_cnt == CNT_SIZE'(OUT_M_SIZE - 1));
    assign o_special = (i_flags != 3'b000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_flags   <= '0;
            r_type    <= 1'b0;
            o_mantisa <= '0;
            o_exp     <= '0;
            o_flags   <= '0;
            o_type    <= 1'b0;
            o_sticky  <= 1'b0;
        end else if (i_ld) begin
            // NOTE: non-blocking here so every register samples the pre-edge values of its peers.
            r_rad   <= i_mantisa;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_exp   <= half_exp(i_exp);
            r_flags <= i_flags;
            r_type  <= i_type;
            if (o_special) begin
                o_mantisa <= '0;
                o_exp     <= i_exp;
                o_flags   <= i_flags;
                o_type    <= i_type;
                o_sticky  <= 1'b0;
            end
        end else if (i_run) begin
            r_rad  <= {r_rad[IN_M_SIZE-3:0], 2'b00};
            r_rem  <= w_rem_next;
            r_root <= w_root_next;
            if (o_tc) begin
                o_mantisa <= w_root_next;
                o_exp     <= r_exp;
                o_flags   <= r_flags;
                o_type    <= r_type;
                o_sticky  <= (w_rem_next != '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_core.sv
// Restoring square-root engine: 53 root bits, one per cycle, plus special-operand bypass.
module sqrt_core
    import sqrt_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    sqrt_core_if.slave  bus
);

    logic w_ld;
    logic w_run;
    logic w_tc;
    logic w_special;

    sqrt_core_cu u_cu (
        .clk       (clk),
        .rst       (rst),
        .i_start   (bus.start_sqrt),
        .i_special (w_special),
        .i_tc      (w_tc),
        .o_ld      (w_ld),
        .o_run     (w_run),
        .o_ready   (bus.ready)
    );

    sqrt_core_dp u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_ld      (w_ld),
        .i_run     (w_run),
        .i_mantisa (bus.in_mantisa),
        .i_exp     (bus.in_exp),
        .i_flags   (bus.in_flags),
        .i_type    (bus.in_type),
        .o_tc      (w_tc),
        .o_special (w_special),
        .o_mantisa (bus.out_mantisa),
        .o_exp     (bus.out_exp),
        .o_flags   (bus.out_flags),
        .o_type    (bus.out_type),
        .o_sticky  (bus.sticky)
    );

endmodule

// File: tb/tb_sqrt_core.sv
// Directed bench for sqrt_core: vector table plus restart-ignore and mid-run reset sequences.
module tb_sqrt_core;
    import sqrt_core_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrt_core_if bus ();

    sqrt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [IN_M_SIZE-1:0]  mant;
        logic [EXP_SIZE-1:0]   exp;
        logic [2:0]            flags;
        logic                  typ;
        logic [OUT_M_SIZE-1:0] r_mant;
        logic [EXP_SIZE-1:0]   r_exp;
        logic                  r_sticky;
        int                    r_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drive(input logic [IN_M_SIZE-1:0] m, input logic [EXP_SIZE-1:0] e,
                         input logic [2:0] f, input logic t);
        bus.in_mantisa = m;
        bus.in_exp     = e;
        bus.in_flags   = f;
        bus.in_type    = t;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mant"},   64'(bus.out_mantisa), 64'd0);
        check({tag, "_exp"},    64'(bus.out_exp),     64'd0);
        check({tag, "_flags"},  64'(bus.out_flags),   64'd0);
        check({tag, "_type"},   64'(bus.out_type),    64'd0);
        check({tag, "_sticky"}, 64'(bus.sticky),      64'd0);
        check({tag, "_ready"},  64'(bus.ready),       64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        drive(v.mant, v.exp, v.flags, v.typ);
        bus.start_sqrt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_sqrt = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"},    64'(lat),             64'(v.r_lat));
        check({tag, "_mant"},   64'(bus.out_mantisa), 64'(v.r_mant));
        check({tag, "_exp"},    64'(bus.out_exp),     64'(v.r_exp));
        check({tag, "_flags"},  64'(bus.out_flags),   64'(v.flags));
        check({tag, "_type"},   64'(bus.out_type),    64'(v.typ));
        check({tag, "_sticky"}, 64'(bus.sticky),      64'(v.r_sticky));
        @(posedge clk);
        #1;
        check({tag, "_ready_width"}, 64'(bus.ready), 64'd0);
    endtask

    initial begin
        int n_ready;
        int first_k;

        vecs[0] = '{106'd1 << 104, 11'd1023, 3'b000, 1'b0, 53'd1 << 52,        11'd1023, 1'b0, 54};
        vecs[1] = '{106'd9 << 102, 11'd1025, 3'b000, 1'b1, 53'd3 << 51,        11'd1024, 1'b0, 54};
        vecs[2] = '{106'd1 << 105, 11'd1023, 3'b000, 1'b0, 53'h16A09E667F3BCC, 11'd1023, 1'b1, 54};
        vecs[3] = '{106'd3 << 104, 11'd1027, 3'b000, 1'b1, 53'h1BB67AE8584CAA, 11'd1025, 1'b1, 54};
        vecs[4] = '{106'd1 << 102, 11'd1021, 3'b000, 1'b0, 53'd1 << 51,        11'd1022, 1'b0, 54};
        vecs[5] = '{106'd1 << 104, 11'd2045, 3'b000, 1'b0, 53'd1 << 52,        11'd1534, 1'b0, 54};
        vecs[6] = '{106'd3 << 104, 11'd1027, 3'b100, 1'b1, 53'd0,              11'd1027, 1'b0, 1};
        vecs[7] = '{106'd1 << 105, 11'd2047, 3'b010, 1'b0, 53'd0,              11'd2047, 1'b0, 1};
        vecs[8] = '{106'd1 << 104, 11'd0,    3'b001, 1'b1, 53'd0,              11'd0,    1'b0, 1};

        bus.start_sqrt = 1'b0;
        drive('0, '0, 3'b000, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Extra start pulses during CALC (cycle 10) and DONE (cycle 54) must be ignored.
        n_ready = 0;
        first_k = 0;
        @(negedge clk);
        drive(106'd9 << 102, 11'd1025, 3'b000, 1'b0);
        bus.start_sqrt = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 115; k++) begin
            @(negedge clk);
            if (k == 10 || k == 54) begin
                drive(106'd1 << 105, 11'd1023, 3'b000, 1'b1);
                bus.start_sqrt = 1'b1;
            end else begin
                bus.start_sqrt = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.ready) begin
                n_ready++;
                if (first_k == 0) first_k = k;
            end
        end
        check("restart_ready_count", 64'(n_ready),         64'd1);
        check("restart_lat",         64'(first_k),         64'd54);
        check("restart_mant",        64'(bus.out_mantisa), 64'(53'd3 << 51));
        check("restart_exp",         64'(bus.out_exp),     64'd1024);
        check("restart_sticky",      64'(bus.sticky),      64'd0);
        check("restart_type",        64'(bus.out_type),    64'd0);

        // Reset in the middle of CALC: outputs clear, no stale ready, clean restart.
        @(negedge clk);
        drive(106'd3 << 104, 11'd1027, 3'b000, 1'b1);
        bus.start_sqrt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_sqrt = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_ready = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) n_ready++;
        end
        check("midrst_no_stale_ready", 64'(n_ready), 64'd0);
        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
